part3_mux: RTL and testbench

- Board-level 2-bit-wide 4-to-1 multiplexer driven from the 10 slide switches, result shown on the LEDs.
- The select and four 2-bit data inputs are packed into SW. The selected value appears combinationally on LED[1:0].
- A clocked side path adds a registered copy of the selected value, a select echo, and a change counter for board debug.

---
 rtl/part3_mux.sv | 56 +++++
 tb/tb_part3_mux.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/part3_mux.sv
// 2-bit 4-to-1 mux from slide switches to LEDs, with a clocked debug side path.
// Latency: LED[1:0] and LED[9:8] combinational; LED[3:2] and LED[7:4] one clk cycle.
// Backpressure: none; the switches are sampled every cycle and the LEDs always update.
//
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; clears the registered mux copy and the change counter
//   SW    - [9:8] select, [7:6] W, [5:4] X, [3:2] V, [1:0] U
//   LED   - [1:0] mux out, [3:2] registered mux out, [7:4] change count, [9:8] select echo
module part3_mux (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] SW,
  output logic [9:0] LED
);

  logic [1:0] sel;
  logic [1:0] mux_d;
  logic [1:0] mux_q;
  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  assign sel = SW[9:8];

  always_comb begin
    mux_d = SW[1:0];
    case (sel)
      2'b00:   mux_d = SW[1:0];
      2'b01:   mux_d = SW[3:2];
      2'b10:   mux_d = SW[5:4];
      default: mux_d = SW[7:6];
    endcase
  end

  // A change is measured against the registered copy, so the first edge after
  // reset counts whenever the selected value is non-zero. 4-bit add wraps 15 -> 0.
  always_comb begin
    cnt_d = cnt_q;
    if (mux_d != mux_q) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_q <= 2'b00;
      cnt_q <= 4'b0000;
    end else begin
      mux_q <= mux_d;
      cnt_q <= cnt_d;
    end
  end

  assign LED = {sel, cnt_q, mux_q, mux_d};

endmodule

// File: tb/tb_part3_mux.sv
module tb_part3_mux;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic [9:0] SW;
  logic [9:0] LED;

  int checks;
  int errors;

  part3_mux dut (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .LED   (LED)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic [9:0] sw;
    logic [1:0] exp_mux;
  } vec_t;

  typedef struct {
    logic [1:0] q;
    logic [3:0] cnt;
  } exp_t;

  exp_t sbq[$];

  // reference model of the registered path
  logic [1:0] m_q;
  logic [3:0] m_cnt;
  bit         m_valid;

  function automatic logic [1:0] ref_mux(input logic [9:0] sw);
    logic [9:0] t;
    t = sw;
    return t[{sw[9:8], 1'b0} +: 2];
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check the combinational
  // outputs and the held registers, push the post-edge expectation, then pop
  // and compare it after the rising edge.
  task automatic step(input logic [9:0] sw, input logic rst);
    exp_t e;
    exp_t got;
    logic [1:0] mv;
    @(negedge clk);
    SW    = sw;
    reset = rst;
    #1;
    mv = ref_mux(sw);
    chk("step_mux", {8'd0, LED[1:0]}, {8'd0, mv});
    chk("step_echo", {8'd0, LED[9:8]}, {8'd0, sw[9:8]});
    if (m_valid) chk("step_hold", {4'd0, LED[7:2]}, {4'd0, m_cnt, m_q});
    if (rst) begin
      m_q   = 2'b00;
      m_cnt = 4'd0;
    end else begin
      if (mv != m_q) m_cnt = m_cnt + 4'd1;
      m_q = mv;
    end
    m_valid = 1'b1;
    e.q   = m_q;
    e.cnt = m_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no entry expected one");
    end else begin
      got = sbq.pop_front();
      chk("step_reg", {4'd0, LED[7:2]}, {4'd0, got.cnt, got.q});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [9:0] sw;
    vecs[0] = '{10'b10_11_01_10_00, 2'b01};
    vecs[1] = '{10'b00_11_10_01_10, 2'b10};
    vecs[2] = '{10'b01_00_00_11_00, 2'b11};
    vecs[3] = '{10'b11_10_00_00_00, 2'b10};
    vecs[4] = '{10'b11_01_11_11_11, 2'b01};
    vecs[5] = '{10'b10_00_10_01_11, 2'b10};

    checks  = 0;
    errors  = 0;
    m_valid = 1'b0;
    m_q     = 2'b00;
    m_cnt   = 4'd0;
    clk_en  = 1'b0;
    reset   = 1'b1;
    SW      = 10'd0;
    #3;

    // exhaustive combinational sweep with the clock idle
    for (int i = 0; i < 1024; i++) begin
      SW = i[9:0];
      #2;
      chk("sweep", {8'd0, LED[1:0]}, {8'd0, ref_mux(i[9:0])});
    end

    // select echo, clk idle, reset high
    SW = 10'b11_00_00_00_00;
    #1;
    chk("echo", {8'd0, LED[9:8]}, 10'd3);

    clk_en = 1'b1;

    // reset state
    step(10'd0, 1'b1);
    step(10'd0, 1'b1);
    chk("reset_state", {4'd0, LED[7:2]}, 10'd0);

    // registered latency
    step(10'b01_00_00_11_00, 1'b0);
    chk("lat_q", {8'd0, LED[3:2]}, 10'd3);
    chk("lat_cnt", {6'd0, LED[7:4]}, 10'd1);

    // table-driven vectors through the scoreboard path
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].sw, 1'b0);
      chk("vec_mux", {8'd0, LED[1:0]}, {8'd0, vecs[i].exp_mux});
      chk("vec_q", {8'd0, LED[3:2]}, {8'd0, vecs[i].exp_mux});
    end

    // counter wrap: 16 changes from a cleared state
    step(10'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sw = (i % 2 == 0) ? 10'b00_00_00_00_01 : 10'd0;
      step(sw, 1'b0);
      chk("wrap_cnt", {6'd0, LED[7:4]}, 10'((i + 1) % 16));
    end

    // reset priority while U toggles
    for (int i = 0; i < 6; i++) begin
      sw = (i % 2 == 0) ? 10'b00_00_00_00_10 : 10'b00_00_00_00_01;
      step(sw, 1'b1);
      chk("rstpri_reg", {4'd0, LED[7:2]}, 10'd0);
      chk("rstpri_mux", {8'd0, LED[1:0]}, {8'd0, sw[1:0]});
    end

    // mid-run reset at count 5, then resume
    step(10'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sw = (i % 2 == 0) ? 10'b00_00_00_00_11 : 10'd0;
      step(sw, 1'b0);
    end
    chk("mid_cnt5", {6'd0, LED[7:4]}, 10'd5);
    step(10'b00_00_00_00_10, 1'b1);
    chk("mid_rst", {4'd0, LED[7:2]}, 10'd0);
    step(10'b00_00_00_00_10, 1'b0);
    chk("mid_resume", {4'd0, LED[7:2]}, {4'd0, 4'd1, 2'b10});

    // random soak through the model
    for (int i = 0; i < 200; i++) begin
      step(10'($urandom_range(0, 1023)), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
